// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined N-way multiplexer.
// Holds the skid-buffer state encoding and the selector-width helper.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // A selector needs at least one bit even for degenerate input counts
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N-way word selector; out-of-range selects yield DEFAULT_VAL.
// Also reports whether the selector addressed an existing input.
module mux_n_comb
  import mux_pkg::*;
#(
  parameter int              WIDTH       = 32,
  parameter int              N_IN        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  parameter int              SEL_W       = sel_width(N_IN)
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]      data,
  output logic                  in_range
);

  logic [WIDTH-1:0] data_s;
  logic             in_range_s;
  logic             hit_s;

  // Scan every input slot; a match overrides the default word
  always_comb begin
    data_s     = DEFAULT_VAL;
    in_range_s = 1'b0;
    hit_s      = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      hit_s      = (sel == SEL_W'(k));
      data_s     = hit_s ? in_bus[k*WIDTH +: WIDTH] : data_s;
      in_range_s = in_range_s | hit_s;
    end
  end

  assign data     = data_s;
  assign in_range = in_range_s;

endmodule

// File: rtl/mux_n_pipe.sv
// Pipelined N-way multiplexer behind a two-entry skid buffer, one-cycle latency.
// Optional sticky out-of-range flag enabled by defining MUX_N_PIPE_SEL_ERR_EN.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               N_IN        = 8,
  parameter int               SEL_W       = sel_width(N_IN),
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
`ifdef MUX_N_PIPE_SEL_ERR_EN
  output logic                  sel_err,
  input  logic                  err_clr,
`endif
  output logic [SEL_W-1:0]      out_sel
);

  state_t           state_r, state_s;
  logic             in_ready_r, out_valid_r;
  logic [WIDTH-1:0] head_data_r, tail_data_r, new_data_s;
  logic [SEL_W-1:0] head_sel_r, tail_sel_r;
  logic             in_range_s;
  logic             in_fire_s, out_fire_s;
  logic             load_head_s, load_tail_s, head_from_tail_s;

  mux_n_comb #(
    .WIDTH       (WIDTH),
    .N_IN        (N_IN),
    .DEFAULT_VAL (DEFAULT_VAL),
    .SEL_W       (SEL_W)
  ) u_comb (
    .sel      (sel),
    .in_bus   (in_bus),
    .data     (new_data_s),
    .in_range (in_range_s)
  );

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Next-state and buffer-steering decode
  always_comb begin
    state_s          = state_r;
    load_head_s      = 1'b0;
    load_tail_s      = 1'b0;
    head_from_tail_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_fire_s) begin
          state_s     = ONE;
          load_head_s = 1'b1;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        case ({in_fire_s, out_fire_s})
          2'b10: begin
            state_s     = TWO;
            load_tail_s = 1'b1;
          end
          2'b01:   state_s = EMPTY;
          2'b11: begin
            state_s     = ONE;
            load_head_s = 1'b1;
          end
          default: state_s = ONE;
        endcase
      end
      TWO: begin
        if (out_fire_s) begin
          state_s          = ONE;
          head_from_tail_s = 1'b1;
        end else begin
          state_s = TWO;
        end
      end
      default: state_s = EMPTY;
    endcase
  end

  // State, handshake flags and buffer registers; handshake flags follow the next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      head_data_r <= DEFAULT_VAL;
      head_sel_r  <= '0;
      tail_data_r <= DEFAULT_VAL;
      tail_sel_r  <= '0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != TWO);
      out_valid_r <= (state_s != EMPTY);
      if (load_head_s) begin
        head_data_r <= new_data_s;
        head_sel_r  <= sel;
      end else if (head_from_tail_s) begin
        head_data_r <= tail_data_r;
        head_sel_r  <= tail_sel_r;
      end else begin
        head_data_r <= head_data_r;
        head_sel_r  <= head_sel_r;
      end
      if (load_tail_s) begin
        tail_data_r <= new_data_s;
        tail_sel_r  <= sel;
      end else begin
        tail_data_r <= tail_data_r;
        tail_sel_r  <= tail_sel_r;
      end
    end
  end

`ifdef MUX_N_PIPE_SEL_ERR_EN
  logic sel_err_r;

  // Sticky error flag; a new error beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_err_r <= 1'b0;
    end else if (in_fire_s && !in_range_s) begin
      sel_err_r <= 1'b1;
    end else if (err_clr) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= sel_err_r;
    end
  end

  assign sel_err = sel_err_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = head_data_r;
  assign out_sel   = head_sel_r;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed self-checking bench for mux_n_pipe with N_IN=7, WIDTH=32.
// Sticky-flag checks are compiled in when MUX_N_PIPE_SEL_ERR_EN is defined.
module tb_mux_n_pipe;

  localparam int WIDTH = 32;
  localparam int N_IN  = 7;
  localparam int SEL_W = 3;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [SEL_W-1:0]      sel;
  logic [N_IN*WIDTH-1:0] in_bus;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
`ifdef MUX_N_PIPE_SEL_ERR_EN
  logic                  sel_err;
  logic                  err_clr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mux_n_pipe #(
    .WIDTH       (WIDTH),
    .N_IN        (N_IN),
    .SEL_W       (SEL_W),
    .DEFAULT_VAL (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .in_bus    (in_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MUX_N_PIPE_SEL_ERR_EN
    .sel_err   (sel_err),
    .err_clr   (err_clr),
`endif
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [34:0] q[$];
  logic [34:0] e;
  int          n_acc;
  int          n_out;
  int unsigned s;

  initial begin
    for (int k = 0; k < N_IN; k++) in_bus[k*WIDTH +: WIDTH] = 32'h0000_1000 + 32'(k);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = 3'd0;
`ifdef MUX_N_PIPE_SEL_ERR_EN
    err_clr   = 1'b0;
`endif
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  out_data,           32'h0000_0000);
    chk("rst_out_sel",   {29'd0, out_sel},   32'd0);
`ifdef MUX_N_PIPE_SEL_ERR_EN
    chk("rst_sel_err",   {31'd0, sel_err},   32'd0);
`endif

    // Basic select with one-cycle latency
    reset_n   = 1'b1;
    out_ready = 1'b1;
    sel       = 3'd5;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    sel       = 3'd2;
    chk("sel5_valid", {31'd0, out_valid}, 32'd1);
    chk("sel5_data",  out_data,           32'h0000_1005);
    chk("sel5_sel",   {29'd0, out_sel},   32'd5);
    step();
    chk("sel5_drain", {31'd0, out_valid}, 32'd0);

    // Out-of-range select gives default value
    sel      = 3'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("oor_data",  out_data,         32'h0000_0000);
    chk("oor_sel",   {29'd0, out_sel}, 32'd7);
`ifdef MUX_N_PIPE_SEL_ERR_EN
    chk("oor_err_set", {31'd0, sel_err}, 32'd1);
`endif
    step();
    chk("oor_drain", {31'd0, out_valid}, 32'd0);
`ifdef MUX_N_PIPE_SEL_ERR_EN
    chk("oor_err_hold", {31'd0, sel_err}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("oor_err_clr", {31'd0, sel_err}, 32'd0);
    sel      = 3'd7;
    in_valid = 1'b1;
    err_clr  = 1'b1;
    step();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    chk("oor_set_wins", {31'd0, sel_err}, 32'd1);
    step();
    chk("oor_drain2", {31'd0, out_valid}, 32'd0);
`endif

    // Skid buffer: stall with A, B, C offered
    out_ready = 1'b0;
    sel       = 3'd1;
    in_valid  = 1'b1;
    step();
    chk("skid_a_ready", {31'd0, in_ready}, 32'd1);
    chk("skid_a_data",  out_data,          32'h0000_1001);
    sel = 3'd2;
    step();
    chk("skid_two_ready", {31'd0, in_ready}, 32'd0);
    chk("skid_two_data",  out_data,          32'h0000_1001);
    sel = 3'd3;
    step();
    chk("skid_hold_ready", {31'd0, in_ready}, 32'd0);
    chk("skid_hold_data",  out_data,          32'h0000_1001);
    chk("skid_hold_sel",   {29'd0, out_sel},  32'd1);
    out_ready = 1'b1;
    step();
    chk("skid_b_data",  out_data,          32'h0000_1002);
    chk("skid_b_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("skid_c_data",  out_data,           32'h0000_1003);
    chk("skid_c_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("skid_empty", {31'd0, out_valid}, 32'd0);

    // Sustained throughput with scoreboard
    q.delete();
    n_acc = 0;
    n_out = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s        = $urandom_range(7, 0);
      sel      = s[2:0];
      in_valid = 1'b1;
      if (in_ready) begin
        q.push_back({s[2:0], (s == 32'd7) ? 32'h0000_0000 : 32'h0000_1000 + s});
        n_acc++;
      end
      step();
      if (out_valid) begin
        n_out++;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("tput_data", out_data, e[31:0]);
          chk("tput_sel", {29'd0, out_sel}, {29'd0, e[34:32]});
        end else begin
          chk("tput_spurious", {31'd0, out_valid}, 32'd0);
        end
      end
    end
    in_valid = 1'b0;
    step();
    chk("tput_drained", {31'd0, out_valid}, 32'd0);
    chk("tput_accepted", 32'(n_acc), 32'd100);
    chk("tput_outputs",  32'(n_out), 32'd100);

    // Reset while full discards the buffered words
    out_ready = 1'b0;
    sel       = 3'd4;
    in_valid  = 1'b1;
    step();
    sel = 3'd6;
    step();
    chk("rst2_full", {31'd0, in_ready}, 32'd0);
    in_valid  = 1'b0;
    reset_n   = 1'b0;
    out_ready = 1'b1;
    step();
    reset_n = 1'b1;
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst2_out_data",  out_data,           32'h0000_0000);
    chk("rst2_out_sel",   {29'd0, out_sel},   32'd0);
    step();
    chk("rst2_no_out_a", {31'd0, out_valid}, 32'd0);
    step();
    chk("rst2_no_out_b", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_pipe.md
MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input and of the output.
REQ-002 Parameter N_IN, default 8, number of data inputs; legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(N_IN), selector width.
REQ-004 Parameter DEFAULT_VAL, default 0, output value for an out-of-range select.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 in_valid  input  1  upstream offers sel and in_bus.
REQ-008 in_ready  output  1  block accepts the offer this cycle; driven from a register.
REQ-009 sel  input  SEL_W  input index to forward.
REQ-010 in_bus  input  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-011 out_valid  output  1  out_data and out_sel are valid.
REQ-012 out_ready  input  1  downstream accepts the output this cycle.
REQ-013 out_data  output  WIDTH  selected word.
REQ-014 out_sel  output  SEL_W  selector value that produced out_data.
REQ-015 sel_err  output  1  sticky out-of-range flag; present only under MUX_N_PIPE_SEL_ERR_EN.
REQ-016 err_clr  input  1  clears sel_err; present only under MUX_N_PIPE_SEL_ERR_EN.

Function
REQ-017 Input handshake fires when in_valid and in_ready are both high; output handshake fires when out_valid and out_ready are both high.
REQ-018 On input handshake the block captures {in_bus[sel], sel}, or {DEFAULT_VAL, sel} when sel >= N_IN.
REQ-019 Latency is one cycle: a word accepted at edge t appears on out_data after edge t when the buffer was empty.
REQ-020 Storage is a two-entry skid buffer; FSM states EMPTY, ONE, TWO.
REQ-021 EMPTY: input handshake -> ONE; otherwise stay.
REQ-022 ONE: input only -> TWO; output only -> EMPTY; both, or neither -> ONE.
REQ-023 TWO: output handshake -> ONE; input handshakes are impossible.
REQ-024 in_ready is high in EMPTY and ONE and low in TWO.
REQ-025 out_valid is high in ONE and TWO.
REQ-026 Words leave in acceptance order; the block never drops or duplicates a word.
REQ-027 out_data and out_sel stay stable while out_valid is high and out_ready is low.
REQ-028 Sustained in_valid=1 with out_ready=1 gives one word per cycle.
REQ-029 Inputs in_bus and sel are sampled only on an input handshake; changes at other times have no effect.

Reset
REQ-030 When reset_n is low at a rising edge: state -> EMPTY, out_valid=0, in_ready=1 on the following cycle, out_data=DEFAULT_VAL, out_sel=0, sel_err=0.
REQ-031 Reset asserted mid-transfer discards any buffered words and no output handshake completes in that cycle.

Configuration
REQ-032 Macro MUX_N_PIPE_SEL_ERR_EN defined: sel_err is set on any input handshake with sel >= N_IN.
REQ-033 With the macro defined, sel_err holds until err_clr=1 or reset; when set and clear coincide, set wins.
REQ-034 Macro undefined: the sel_err and err_clr ports and their logic are absent; out-of-range behaviour per REQ-018 is unchanged.

Structure
REQ-035 Shared package mux_pkg holds the FSM state enum (EMPTY, ONE, TWO) and the sel-width helper function.
REQ-036 Combinational selection lives in the sub-module mux_n_comb (parameters WIDTH, N_IN, DEFAULT_VAL); mux_n_pipe instantiates it once.

Verification
REQ-037 N_IN=7, inputs k = 0x1000+k, sel=5, out_ready=1 -> out_data=0x1005, out_sel=5, one cycle after acceptance.
REQ-038 N_IN=7, sel=7 -> out_data=0x00000000; with macro defined sel_err=1 until err_clr pulses, and set wins when sel=7 and err_clr=1 coincide.
REQ-039 out_ready=0 while three words A, B, C are offered -> A and B accepted, in_ready=0 in TWO; release out_ready -> A, B, C delivered in order with no loss.
REQ-040 Continuous in_valid=1 and out_ready=1 for 100 cycles with a random sel -> 100 outputs, throughput 1 word/cycle, scoreboard matches.
REQ-041 reset_n=0 while in state TWO -> next cycle out_valid=0, in_ready=1, out_data=0, and the buffered words are never output.
